dht11_interface: RTL

Single-wire DHT11 reader for TUSCA; sits directly downstream of the system control unit. On a one-cycle `medir` pulse it drives the start sequence on the sensor line and samples the 40-bit response, then validates the checksum. It reports either a one-cycle `pronto` with fresh humidity and temperature registers, or a one-cycle `erro`. The control unit's `pronto_medida` and `erro_medida` inputs connect to these two pulses.

---
 rtl/tusca_pkg.sv | 27 ++
 rtl/tick_us.sv | 28 ++
 rtl/dht11_interface.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tusca_pkg.sv
// rtl/tusca_pkg.sv - shared TUSCA state codes and DHT11 timing defaults
package tusca_pkg;

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    INICIO_BAIXO = 4'd1,
    LIBERA       = 4'd2,
    RESP_BAIXO   = 4'd3,
    RESP_ALTO    = 4'd4,
    BIT_BAIXO    = 4'd5,
    BIT_ALTO     = 4'd6,
    VERIFICA     = 4'd7,
    PRONTO       = 4'd8,
    FALHA        = 4'd9
  } estado_t;

  localparam int DHT_START_LOW_US  = 18000;
  localparam int DHT_TIMEOUT_US    = 200;
  localparam int DHT_BIT_LIMIAR_US = 50;

  function automatic logic checksum_ok(input logic [39:0] frame);
    logic [7:0] soma;
    soma = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return soma == frame[7:0];
  endfunction

endpackage

// File: rtl/tick_us.sv
// rtl/tick_us.sv - microsecond prescaler, restartable so each state's
// microsecond count is phase-aligned to the state entry
module tick_us #(
  parameter int CLKS_PER_US = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_US - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick = (cnt_q == LAST);
    if (clr || tick) cnt_d = '0;
    else             cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dht11_interface.sv
// rtl/dht11_interface.sv - DHT11 single-wire reader: start pulse, 40-bit
// capture, checksum check, one-cycle pronto/erro result pulses
module dht11_interface
  import tusca_pkg::*;
#(
  parameter int CLKS_PER_US   = 50,
  parameter int START_LOW_US  = DHT_START_LOW_US,
  parameter int TIMEOUT_US    = DHT_TIMEOUT_US,
  parameter int BIT_LIMIAR_US = DHT_BIT_LIMIAR_US
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       dht_in,
  output logic       dht_puxa_baixo,
  output logic [7:0] umidade_int,
  output logic [7:0] umidade_dec,
  output logic [7:0] temperatura_int,
  output logic [7:0] temperatura_dec,
  output logic       pronto,
  output logic       erro,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  localparam logic [15:0] START_LAST = 16'(START_LOW_US - 1);
  localparam logic [15:0] TIMEOUT    = 16'(TIMEOUT_US);
  localparam logic [15:0] LIMIAR     = 16'(BIT_LIMIAR_US);

  estado_t     state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [15:0] us_cnt_q, us_cnt_d;
  logic [5:0]  bit_idx_q, bit_idx_d;
  logic [39:0] shift_q, shift_d;
  logic [31:0] dados_q, dados_d;
  logic        puxa_q, pronto_q, erro_q, ocupado_q;
  logic        tick, entering, fall, rise;

  tick_us #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .clock (clock),
    .reset (reset),
    .clr   (entering),
    .tick  (tick)
  );

  assign fall = prev_q & ~sync2_q;
  assign rise = ~prev_q & sync2_q;

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      OCIOSO:       if (medir) state_d = INICIO_BAIXO;
      INICIO_BAIXO: if (tick && us_cnt_q == START_LAST) state_d = LIBERA;
      LIBERA:       if (fall) state_d = RESP_BAIXO;
      RESP_BAIXO:   if (rise) state_d = RESP_ALTO;
      RESP_ALTO: begin
        if (fall) begin
          state_d   = BIT_BAIXO;
          bit_idx_d = '0;
        end
      end
      BIT_BAIXO:    if (rise) state_d = BIT_ALTO;
      BIT_ALTO: begin
        if (fall) begin
          shift_d   = {shift_q[38:0], (us_cnt_q > LIMIAR)};
          bit_idx_d = bit_idx_q + 6'd1;
          state_d   = (bit_idx_q == 6'd39) ? VERIFICA : BIT_BAIXO;
        end
      end
      VERIFICA:     state_d = checksum_ok(shift_q) ? PRONTO : FALHA;
      PRONTO:       state_d = OCIOSO;
      FALHA:        state_d = OCIOSO;
      default:      state_d = OCIOSO;
    endcase
    // Any sensor-driven phase that overstays aborts the read.
    if ((state_q inside {LIBERA, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO}) &&
        us_cnt_q > TIMEOUT)
      state_d = FALHA;

    entering = (state_d != state_q);
    if (entering)                           us_cnt_d = '0;
    else if (tick && us_cnt_q != 16'hFFFF)  us_cnt_d = us_cnt_q + 16'd1;
    else                                    us_cnt_d = us_cnt_q;

    dados_d = (state_d == PRONTO) ? shift_q[39:8] : dados_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= OCIOSO;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      us_cnt_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      dados_q   <= '0;
      puxa_q    <= 1'b0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= dht_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      us_cnt_q  <= us_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      dados_q   <= dados_d;
      puxa_q    <= (state_d == INICIO_BAIXO);
      pronto_q  <= (state_d == PRONTO);
      erro_q    <= (state_d == FALHA);
      ocupado_q <= (state_d != OCIOSO);
    end
  end

  assign dht_puxa_baixo  = puxa_q;
  assign pronto          = pronto_q;
  assign erro            = erro_q;
  assign ocupado         = ocupado_q;
  assign db_estado       = state_q;
  assign umidade_int     = dados_q[31:24];
  assign umidade_dec     = dados_q[23:16];
  assign temperatura_int = dados_q[15:8];
  assign temperatura_dec = dados_q[7:0];

endmodule
